reconfig_ctrl: RTL

Initiator side of the accelerator kernel's configuration ID interface. Accepts kernel-switch requests from the HWPE control slave over a valid/ready handshake. Drains in-flight datapath tokens, then drives the registered ID to the configurator, waits a settle window, and returns a response. It guarantees the ID never changes while tokens are in flight.

---
 rtl/reconfig_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/reconfig_ctrl.sv
// Initiator side of the kernel configuration ID interface: drains in-flight
// tokens before switching ID_o, then waits a settle window and responds.
module reconfig_ctrl #(
    parameter int ID_W       = 8,
    parameter int N_CFG      = 3,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    input  logic [ID_W-1:0] req_id_i,
    output logic            req_ready_o,
    output logic            rsp_valid_o,
    output logic            rsp_err_o,
    input  logic            rsp_ready_i,
    input  logic            dp_issue_i,
    input  logic            dp_retire_i,
    output logic            stall_o,
    output logic [ID_W-1:0] ID_o,
    output logic            cfg_valid_o,
    output logic            busy_o
);

    localparam int              SC_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [ID_W-1:0] MAX_ID  = ID_W'(N_CFG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, DRAIN, SWITCH, SETTLE, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] pend_id;
    logic [CNT_W-1:0] inflight;
    logic [SC_W-1:0] settle_cnt;

    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign stall_o     = !(cfg_valid_o && (state == IDLE || state == RESP));

    // Token occupancy runs independently of the FSM so tokens issued while
    // stalled are still tracked and waited for.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight <= '0;
        end else begin
            case ({dp_issue_i, dp_retire_i})
                2'b10:   if (inflight != CNT_MAX) inflight <= inflight + 1'b1;
                2'b01:   if (inflight != '0)      inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            pend_id     <= '0;
            settle_cnt  <= '0;
            ID_o        <= '0;
            cfg_valid_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        pend_id <= req_id_i;
                        if (req_id_i == '0 || req_id_i > MAX_ID) begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            state       <= RESP;
                        end else if (req_id_i == ID_o && cfg_valid_o) begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            state       <= RESP;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (inflight == '0) state <= SWITCH;
                end
                // ID_o only ever changes here, after the datapath is empty
                SWITCH: begin
                    ID_o       <= pend_id;
                    settle_cnt <= '0;
                    if (SETTLE_CYC == 0) begin
                        cfg_valid_o <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        state       <= RESP;
                    end else begin
                        cfg_valid_o <= 1'b0;
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SC_LAST) begin
                        cfg_valid_o <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        state       <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
